// File: rtl/cpu_rst_pkg.sv
// Shared types and encodings for the SoC reset sequencer.
package cpu_rst_pkg;

  typedef enum logic [1:0] {
    ST_POR_HOLD = 2'd0,
    ST_SW_HOLD  = 2'd1,
    ST_RELEASE  = 2'd2,
    ST_RUN      = 2'd3
  } rst_state_e;

  localparam logic [1:0] CAUSE_POR = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset synchronizer: asserts asynchronously, releases after SYNC_STAGES clock edges.
module rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic i_rst_n,
  output logic o_rst_n
);

  logic [SYNC_STAGES-1:0] r_sync;

  // Shift ones in after release; any low pulse on i_rst_n clears the whole chain at once.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {SYNC_STAGES{1'b0}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign o_rst_n = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/cpu_reset_seq.sv
// Reset sequencer: holds all channels after POR, then releases them one by one with a fixed
// stagger; a masked software reset re-asserts a subset and releases it the same way.
module cpu_reset_seq
  import cpu_rst_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYC    = 16,
  parameter int STAGGER_CYC = 4,
  parameter int SW_HOLD_CYC = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sw_rst_req,
  input  logic [N_CH-1:0] sw_rst_mask,
  output logic [N_CH-1:0] rst_out,
  output logic            rst_done,
  output logic            busy,
  output logic [1:0]      rst_cause
);

  localparam int CNT_W = $clog2(max3(HOLD_CYC, SW_HOLD_CYC, STAGGER_CYC) + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] SW_HOLD_LAST = CNT_W'(SW_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYC - 1);

  logic             w_rst_n;
  rst_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_last;
  logic [N_CH-1:0]  r_rst_out, w_rst_out_nxt, w_low_bit;
  logic             r_done, w_done_nxt;
  logic             r_busy, w_busy_nxt;
  logic [1:0]       r_cause, w_cause_nxt;
  logic             w_release, w_last_ch, w_sw_accept;

  rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rst_sync (
    .clk     (clk),
    .i_rst_n (reset),
    .o_rst_n (w_rst_n)
  );

  // r_rst_out doubles as the set of channels still waiting for release (the latched mask).
  assign w_low_bit   = r_rst_out & (~r_rst_out + N_CH'(1'b1));
  assign w_last_ch   = (r_rst_out & ~w_low_bit) == {N_CH{1'b0}};
  assign w_sw_accept = (r_state == ST_RUN) && sw_rst_req && (sw_rst_mask != {N_CH{1'b0}});

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state   <= ST_POR_HOLD;
      r_cnt     <= {CNT_W{1'b0}};
      r_rst_out <= {N_CH{1'b1}};
      r_done    <= 1'b0;
      r_busy    <= 1'b1;
      r_cause   <= CAUSE_POR;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rst_out <= w_rst_out_nxt;
      r_done    <= w_done_nxt;
      r_busy    <= w_busy_nxt;
      r_cause   <= w_cause_nxt;
    end
  end

  // Terminal count of the phase currently being timed.
  always_comb begin
    w_cnt_last = STAGGER_LAST;
    case (r_state)
      ST_POR_HOLD: w_cnt_last = HOLD_LAST;
      ST_SW_HOLD:  w_cnt_last = SW_HOLD_LAST;
      ST_RELEASE:  w_cnt_last = STAGGER_LAST;
      default:     w_cnt_last = STAGGER_LAST;
    endcase
  end

  // Next state: every timed phase ends by releasing the lowest pending channel.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_release   = 1'b0;
    case (r_state)
      ST_POR_HOLD, ST_SW_HOLD, ST_RELEASE: begin
        if (r_cnt == w_cnt_last) begin
          w_release   = 1'b1;
          w_cnt_nxt   = {CNT_W{1'b0}};
          w_state_nxt = w_last_ch ? ST_RUN : ST_RELEASE;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (w_sw_accept) begin
          w_state_nxt = ST_SW_HOLD;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_POR_HOLD;
        w_cnt_nxt   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    w_rst_out_nxt = r_rst_out;
    w_done_nxt    = r_done;
    w_busy_nxt    = r_busy;
    w_cause_nxt   = r_cause;
    if (w_release) begin
      w_rst_out_nxt = r_rst_out & ~w_low_bit;
      if (w_last_ch) begin
        w_done_nxt = 1'b1;
        w_busy_nxt = 1'b0;
      end else begin
        w_done_nxt = 1'b0;
        w_busy_nxt = 1'b1;
      end
    end else if (w_sw_accept) begin
      w_rst_out_nxt = r_rst_out | sw_rst_mask;
      w_done_nxt    = 1'b0;
      w_busy_nxt    = 1'b1;
      w_cause_nxt   = CAUSE_SW;
    end else begin
      w_rst_out_nxt = r_rst_out;
    end
  end

  assign rst_out   = r_rst_out;
  assign rst_done  = r_done;
  assign busy      = r_busy;
  assign rst_cause = r_cause;

endmodule

// File: tb/tb_cpu_reset_seq.sv
// Scoreboard bench for cpu_reset_seq: default instance plus a 1-channel instance.
module tb_cpu_reset_seq;

  typedef struct packed {
    logic [3:0] ro;
    logic       done;
    logic       busy;
    logic [1:0] cause;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       sw_rst_req;
  logic [3:0] sw_rst_mask;
  logic [3:0] rst_out;
  logic       rst_done, busy;
  logic [1:0] rst_cause;

  logic       rst1;
  logic       sw_rst_req1;
  logic [0:0] sw_rst_mask1;
  logic [0:0] rst_out1;
  logic       rst_done1, busy1;
  logic [1:0] rst_cause1;

  exp_t q[$];
  exp_t e, got;
  int   n_checks = 0;
  int   n_pass   = 0;

  cpu_reset_seq dut (
    .clk(clk), .reset(reset), .sw_rst_req(sw_rst_req), .sw_rst_mask(sw_rst_mask),
    .rst_out(rst_out), .rst_done(rst_done), .busy(busy), .rst_cause(rst_cause)
  );

  cpu_reset_seq #(.N_CH(1), .SYNC_STAGES(3), .HOLD_CYC(3)) dut1 (
    .clk(clk), .reset(rst1), .sw_rst_req(sw_rst_req1), .sw_rst_mask(sw_rst_mask1),
    .rst_out(rst_out1), .rst_done(rst_done1), .busy(busy1), .rst_cause(rst_cause1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs k edges after T0 of a default POR.
  function automatic exp_t por_exp(input int k);
    exp_t r;
    r.ro = 4'b0000;
    for (int i = 0; i < 4; i++) r.ro[i] = (k < 16 + 4 * i);
    r.done  = (k >= 28);
    r.busy  = (k < 28);
    r.cause = 2'b01;
    return r;
  endfunction

  // Expected outputs m edges after a SW reset with the given mask is accepted.
  function automatic exp_t sw_exp(input logic [3:0] mask, input int m);
    exp_t r;
    int p;
    int last;
    p = 0;
    last = 0;
    r.ro = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        r.ro[i] = (m < 8 + 4 * p);
        last = 8 + 4 * p;
        p++;
      end
    end
    r.done  = (m >= last);
    r.busy  = (m < last);
    r.cause = 2'b10;
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b0; rst1 = 1'b0;
    sw_rst_req = 1'b0; sw_rst_mask = 4'b0000;
    sw_rst_req1 = 1'b0; sw_rst_mask1 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      q.push_back('{ro: 4'hF, done: 1'b0, busy: 1'b1, cause: 2'b01});
      @(posedge clk); #1;
      got = {rst_out, rst_done, busy, rst_cause};
      e = q.pop_front();
      n_checks++;
      if (got !== e) $display("FAIL reset_hold c=%0d got=%b exp=%b", c, got, e);
      else n_pass++;
      n_checks++;
      if ({rst_out1, rst_done1, busy1, rst_cause1} !== 5'b1_0_1_01)
        $display("FAIL reset_hold_1ch c=%0d got=%b exp=10101", c, {rst_out1, rst_done1, busy1, rst_cause1});
      else n_pass++;
    end
  endtask

  // Call with reset already risen and no posedge since; poke raises sw_rst_req during the hold.
  task automatic test_por_timing(input string tag, input bit poke);
    for (int n = 1; n <= 32; n++) q.push_back(por_exp(n - 2));
    for (int n = 1; n <= 32; n++) begin
      @(posedge clk); #1;
      if (poke && n == 8) begin sw_rst_req = 1'b1; sw_rst_mask = 4'hF; end
      if (poke && n == 9) begin sw_rst_req = 1'b0; sw_rst_mask = 4'h0; end
      got = {rst_out, rst_done, busy, rst_cause};
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL %s scoreboard empty n=%0d", tag, n);
      end else begin
        e = q.pop_front();
        n_checks++;
        if (got !== e) $display("FAIL %s n=%0d got=%b exp=%b", tag, n, got, e);
        else n_pass++;
      end
    end
  endtask

  task automatic test_por();
    @(negedge clk); reset = 1'b1;
    test_por_timing("por", 1'b0);
  endtask

  task automatic test_ignored_por_hold();
    @(negedge clk); reset = 1'b0;
    @(negedge clk); @(negedge clk); reset = 1'b1;
    test_por_timing("por_req_in_hold", 1'b1);
  endtask

  // second_req: re-request during SW_HOLD; the mask input is also changed after acceptance.
  task automatic test_sw(input string tag, input logic [3:0] mask, input bit second_req);
    @(negedge clk); sw_rst_req = 1'b1; sw_rst_mask = mask;
    for (int m = 0; m <= 20; m++) q.push_back(sw_exp(mask, m));
    for (int m = 0; m <= 20; m++) begin
      @(posedge clk); #1;
      if (m == 0) begin sw_rst_req = 1'b0; sw_rst_mask = ~mask; end
      if (second_req && m == 3) begin sw_rst_req = 1'b1; sw_rst_mask = 4'hF; end
      if (second_req && m == 4) sw_rst_req = 1'b0;
      got = {rst_out, rst_done, busy, rst_cause};
      e = q.pop_front();
      n_checks++;
      if (got !== e) $display("FAIL %s m=%0d got=%b exp=%b", tag, m, got, e);
      else n_pass++;
    end
    sw_rst_mask = 4'h0;
  endtask

  task automatic test_sw_reset();
    test_sw("sw_1010", 4'b1010, 1'b0);
  endtask

  task automatic test_back_to_back();
    test_sw("sw_0111_rereq", 4'b0111, 1'b1);
  endtask

  task automatic test_ignored_mask0();
    @(negedge clk); sw_rst_req = 1'b1; sw_rst_mask = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      q.push_back('{ro: 4'h0, done: 1'b1, busy: 1'b0, cause: 2'b10});
      @(posedge clk); #1;
      if (c == 1) sw_rst_req = 1'b0;
      got = {rst_out, rst_done, busy, rst_cause};
      e = q.pop_front();
      n_checks++;
      if (got !== e) $display("FAIL mask0 c=%0d got=%b exp=%b", c, got, e);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_sw();
    @(negedge clk); sw_rst_req = 1'b1; sw_rst_mask = 4'b1010;
    @(posedge clk); #1; sw_rst_req = 1'b0; sw_rst_mask = 4'b0000;
    @(posedge clk); #3;
    reset = 1'b0;
    q.push_back('{ro: 4'hF, done: 1'b0, busy: 1'b1, cause: 2'b01});
    #1;
    got = {rst_out, rst_done, busy, rst_cause};
    e = q.pop_front();
    n_checks++;
    if (got !== e) $display("FAIL mid_sw_async got=%b exp=%b", got, e);
    else n_pass++;
    @(negedge clk); @(negedge clk); reset = 1'b1;
    test_por_timing("por_after_mid_sw", 1'b0);
  endtask

  task automatic test_glitch();
    @(negedge clk); #1 reset = 1'b0;
    q.push_back('{ro: 4'hF, done: 1'b0, busy: 1'b1, cause: 2'b01});
    #1;
    got = {rst_out, rst_done, busy, rst_cause};
    e = q.pop_front();
    n_checks++;
    if (got !== e) $display("FAIL glitch_async got=%b exp=%b", got, e);
    else n_pass++;
    #1 reset = 1'b1;
    test_por_timing("por_after_glitch", 1'b0);
  endtask

  task automatic test_small_params();
    @(negedge clk); rst1 = 1'b1;
    for (int n = 1; n <= 10; n++)
      q.push_back('{ro: {3'b000, (n < 6)}, done: (n >= 6), busy: (n < 6), cause: 2'b01});
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      got = {3'b000, rst_out1, rst_done1, busy1, rst_cause1};
      e = q.pop_front();
      n_checks++;
      if (got !== e) $display("FAIL por_1ch n=%0d got=%b exp=%b", n, got, e);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_por();
    test_ignored_por_hold();
    test_sw_reset();
    test_back_to_back();
    test_ignored_mask0();
    test_reset_mid_sw();
    test_glitch();
    test_small_params();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
